// File: rtl/flappy_pkg.sv
// Shared game constants, FSM encoding and small helpers for the flappy datapath.
package flappy_pkg;

    localparam int unsigned SCREEN_WIDTH = 640;
    localparam int unsigned PIPE_SIZE_X  = 78;
    localparam int unsigned FLOOR_Y      = 418;
    localparam int unsigned X_W          = 32;
    localparam int unsigned LFSR_W       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Rotate a 16-bit word right by sh bits (sh < 16).
    function automatic logic [LFSR_W-1:0] rotr16(input logic [LFSR_W-1:0] v,
                                                 input int unsigned sh);
        logic [LFSR_W-1:0] r;
        r = (v >> sh) | (v << (LFSR_W - sh));
        return r;
    endfunction

endpackage

// File: rtl/pipe_generator_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), free-running every clock.
module lfsr16
    import flappy_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

    // Shift right; feed the outgoing bit back into the tap positions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= seed;
        end else begin
            q <= (q >> 1) ^ (q[0] ? TAP_MASK : '0);
        end
    end

endmodule

// File: rtl/pipe_generator.sv
// Pipe position generator: scrolls a ring of pipes, re-randomises wrapped gaps,
// freezes on collision and pulses pipe_passed when a pipe clears the bird.
module pipe_generator
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_PIPES        = 4,
    parameter int unsigned PIPE_SPACING     = 200,
    parameter int unsigned SCROLL_SPEED     = 2,
    parameter int unsigned BIRD_X           = 100,
    parameter int unsigned GAP_Y_MIN        = 120,
    parameter int unsigned GAP_Y_RANGE_LOG2 = 7,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_tick,
    input  logic                game_start,
    input  logic                collision,
    output logic signed [X_W-1:0] pipeX_1,
    output logic signed [X_W-1:0] pipeX_2,
    output logic signed [X_W-1:0] pipeX_3,
    output logic signed [X_W-1:0] pipeX_4,
    output logic        [X_W-1:0] pipeY_1,
    output logic        [X_W-1:0] pipeY_2,
    output logic        [X_W-1:0] pipeY_3,
    output logic        [X_W-1:0] pipeY_4,
    output logic                pipe_passed,
    output logic                running
);

    localparam logic signed [X_W-1:0] SCREEN_S = X_W'(SCREEN_WIDTH);
    localparam logic signed [X_W-1:0] SIZE_S   = X_W'(PIPE_SIZE_X);
    localparam logic signed [X_W-1:0] SPEED_S  = X_W'(SCROLL_SPEED);
    localparam logic signed [X_W-1:0] BIRD_S   = X_W'(BIRD_X);
    localparam logic signed [X_W-1:0] RING_S   = X_W'(NUM_PIPES * PIPE_SPACING);
    localparam logic        [X_W-1:0] Y_MIN_W  = X_W'(GAP_Y_MIN);
    localparam logic        [X_W-1:0] Y_MID_W  = X_W'(GAP_Y_MIN + 2 ** (GAP_Y_RANGE_LOG2 - 1));

    state_e                 state_q, state_d;
    logic signed [X_W-1:0]  pipe_x_q [NUM_PIPES];
    logic signed [X_W-1:0]  pipe_x_d [NUM_PIPES];
    logic        [X_W-1:0]  pipe_y_q [NUM_PIPES];
    logic        [X_W-1:0]  pipe_y_d [NUM_PIPES];
    logic                   passed_d;
    logic                   running_d;

    logic [LFSR_W-1:0]      lfsr_q;
    logic signed [X_W-1:0]  nx       [NUM_PIPES];
    logic signed [X_W-1:0]  wrap_x   [NUM_PIPES];
    logic signed [X_W-1:0]  start_x  [NUM_PIPES];
    logic        [X_W-1:0]  start_y  [NUM_PIPES];
    logic [LFSR_W-1:0]      rot      [NUM_PIPES];
    logic [NUM_PIPES-1:0]   wrap;
    logic [NUM_PIPES-1:0]   crossed;
    logic        [X_W-1:0]  wrap_y;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .q       (lfsr_q)
    );

    assign wrap_y = Y_MIN_W + X_W'(lfsr_q[GAP_Y_RANGE_LOG2-1:0]);

    // Per-pipe scroll, wrap, restart position and bird-crossing terms.
    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        assign nx[i]      = pipe_x_q[i] - SPEED_S;
        assign wrap[i]    = nx[i] < -SIZE_S;
        assign wrap_x[i]  = nx[i] + RING_S;
        assign start_x[i] = SCREEN_S + X_W'(i * PIPE_SPACING);
        assign rot[i]     = rotr16(lfsr_q, 4 * i);
        assign start_y[i] = Y_MIN_W + X_W'(rot[i][GAP_Y_RANGE_LOG2-1:0]);
        assign crossed[i] = ((pipe_x_q[i] + SIZE_S) >= BIRD_S) && ((nx[i] + SIZE_S) < BIRD_S);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        pipe_x_d = pipe_x_q;
        pipe_y_d = pipe_y_q;
        passed_d = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (game_start) begin
                    state_d  = RUN;
                    pipe_x_d = start_x;
                    pipe_y_d = start_y;
                end
            end
            RUN: begin
                if (collision) begin
                    state_d = HALT;
                end else if (frame_tick) begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if (wrap[i]) begin
                            pipe_x_d[i] = wrap_x[i];
                            pipe_y_d[i] = wrap_y;
                        end else begin
                            pipe_x_d[i] = nx[i];
                        end
                    end
                    passed_d = |crossed;
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pipe_passed <= 1'b0;
            running     <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_q[i] <= SCREEN_S + X_W'(i * PIPE_SPACING);
                pipe_y_q[i] <= Y_MID_W;
            end
        end else begin
            state_q     <= state_d;
            pipe_x_q    <= pipe_x_d;
            pipe_y_q    <= pipe_y_d;
            pipe_passed <= passed_d;
            running     <= running_d;
        end
    end

    assign pipeX_1 = pipe_x_q[0];
    assign pipeX_2 = pipe_x_q[1];
    assign pipeX_3 = pipe_x_q[2];
    assign pipeX_4 = pipe_x_q[3];
    assign pipeY_1 = pipe_y_q[0];
    assign pipeY_2 = pipe_y_q[1];
    assign pipeY_3 = pipe_y_q[2];
    assign pipeY_4 = pipe_y_q[3];

endmodule

// File: tb/tb_pipe_generator.sv
// Directed bench for pipe_generator with an independent LFSR reference.
module tb_pipe_generator;

    logic clk = 1'b0;
    logic reset_n;
    logic frame_tick, game_start, collision;
    logic signed [31:0] pipeX_1, pipeX_2, pipeX_3, pipeX_4;
    logic [31:0] pipeY_1, pipeY_2, pipeY_3, pipeY_4;
    logic pipe_passed, running;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    logic [15:0] e_lfsr;
    logic [31:0] first_y [4];
    logic [31:0] y_tmp;

    pipe_generator dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .game_start  (game_start),
        .collision   (collision),
        .pipeX_1     (pipeX_1),
        .pipeX_2     (pipeX_2),
        .pipeX_3     (pipeX_3),
        .pipeX_4     (pipeX_4),
        .pipeY_1     (pipeY_1),
        .pipeY_2     (pipeY_2),
        .pipeY_3     (pipeY_3),
        .pipeY_4     (pipeY_4),
        .pipe_passed (pipe_passed),
        .running     (running)
    );

    always #5 clk = ~clk;

    // Reference LFSR: bit-level feedback into positions 15, 13, 12 and 10.
    function automatic logic [15:0] m_step(input logic [15:0] v);
        logic [15:0] n;
        logic fb;
        fb = v[0];
        n  = {1'b0, v[15:1]};
        n[15] = n[15] ^ fb;
        n[13] = n[13] ^ fb;
        n[12] = n[12] ^ fb;
        n[10] = n[10] ^ fb;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= m_step(m_lfsr);
    end

    // Expected restart gap for pipe index i (0-based) given the LFSR value.
    function automatic logic [31:0] exp_start_y(input logic [15:0] l, input int i);
        logic [15:0] r;
        logic [31:0] ll;
        ll = {l, l};
        r  = ll[4*i +: 16];
        return 32'd120 + {25'd0, r[6:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic chk_reset_pos(input string tag);
        chk({tag, "_x1"}, pipeX_1, 32'd640);
        chk({tag, "_x2"}, pipeX_2, 32'd840);
        chk({tag, "_x3"}, pipeX_3, 32'd1040);
        chk({tag, "_x4"}, pipeX_4, 32'd1240);
        chk({tag, "_y1"}, pipeY_1, 32'd184);
        chk({tag, "_y4"}, pipeY_4, 32'd184);
        chk({tag, "_run"}, running, 32'd0);
        chk({tag, "_pass"}, pipe_passed, 32'd0);
    endtask

    task automatic start_game(input logic with_collision);
        e_lfsr     = m_lfsr;
        game_start = 1'b1;
        collision  = with_collision;
        @(negedge clk);
        game_start = 1'b0;
        collision  = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        game_start = 1'b0;
        collision  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_reset_pos("reset");

        // IDLE ignores ticks and collision.
        collision = 1'b1;
        tick(1000);
        collision = 1'b0;
        chk_reset_pos("idle");

        // Start: reload positions, gaps from rotated LFSR.
        start_game(1'b0);
        chk("start_run", running, 32'd1);
        chk("start_x1", pipeX_1, 32'd640);
        for (int i = 0; i < 4; i++) first_y[i] = exp_start_y(e_lfsr, i);
        chk("start_y1", pipeY_1, first_y[0]);
        chk("start_y2", pipeY_2, first_y[1]);
        chk("start_y3", pipeY_3, first_y[2]);
        chk("start_y4", pipeY_4, first_y[3]);

        // Scrolling: one-edge latency, then 10 ticks total.
        frame_tick = 1'b1;
        chk("pre_edge_x1", pipeX_1, 32'd640);
        @(negedge clk);
        frame_tick = 1'b0;
        chk("lat_x1", pipeX_1, 32'd638);
        tick(9);
        chk("t10_x1", pipeX_1, 32'd620);
        chk("t10_x4", pipeX_4, 32'd1220);
        chk("t10_run", running, 32'd1);

        // game_start while running is ignored.
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        chk("gs_in_run_x1", pipeX_1, 32'd620);

        // Bird crossing: right edge from 100 to 98 pulses once.
        tick(298);
        chk("x1_24", pipeX_1, 32'd24);
        tick(1);
        chk("x1_22", pipeX_1, 32'd22);
        chk("no_pass_24_22", pipe_passed, 32'd0);
        tick(1);
        chk("x1_20", pipeX_1, 32'd20);
        chk("pass_22_20", pipe_passed, 32'd1);
        @(negedge clk);
        chk("pass_one_clk", pipe_passed, 32'd0);
        tick(1);
        chk("no_pass_20_18", pipe_passed, 32'd0);

        // Wrap at -80 < -78.
        tick(48);
        chk("x1_m78", pipeX_1, -32'sd78);
        e_lfsr = m_lfsr;
        tick(1);
        chk("wrap_x1", pipeX_1, 32'd720);
        chk("wrap_y1", pipeY_1, 32'd120 + {25'd0, e_lfsr[6:0]});
        y_tmp = pipeY_1;
        chk("wrap_y1_range", 32'((y_tmp >= 32'd120) && (y_tmp <= 32'd247)), 32'd1);
        chk("nowrap_x2", pipeX_2, 32'd120);
        chk("nowrap_y2", pipeY_2, first_y[1]);

        // Collision beats frame_tick; HALT freezes everything.
        collision  = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        collision  = 1'b0;
        frame_tick = 1'b0;
        chk("halt_run", running, 32'd0);
        chk("halt_x1", pipeX_1, 32'd720);
        chk("halt_pass", pipe_passed, 32'd0);
        tick(5);
        chk("halt_tick_x1", pipeX_1, 32'd720);
        chk("halt_tick_x2", pipeX_2, 32'd120);

        // Restart with simultaneous collision.
        start_game(1'b1);
        chk("restart_run", running, 32'd1);
        chk("restart_x1", pipeX_1, 32'd640);
        chk("restart_x4", pipeX_4, 32'd1240);
        chk("restart_y1", pipeY_1, exp_start_y(e_lfsr, 0));
        chk("restart_y3", pipeY_3, exp_start_y(e_lfsr, 2));

        // Asynchronous reset between edges.
        tick(3);
        chk("pre_rst_x1", pipeX_1, 32'd634);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_pos("async_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Same start timing after reset reproduces the first gap set.
        tick(1000);
        start_game(1'b0);
        chk("repro_y1", pipeY_1, first_y[0]);
        chk("repro_y2", pipeY_2, first_y[1]);
        chk("repro_y3", pipeY_3, first_y[2]);
        chk("repro_y4", pipeY_4, first_y[3]);
        chk("repro_y1_model", pipeY_1, exp_start_y(e_lfsr, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
